// File: rtl/branch_resolution.sv
// Branch resolution FSM: tracks a BEQ/BNE from ID through EX to MEM and drives redirect/flush.
// Optional BRANCH_STATS_EN builds saturating resolved/taken branch counters.
module branch_resolution (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  instruccion,
    input  logic        bubble,
    input  logic        zero,
    input  logic [31:0] pc_target,
    output logic        branch_mem,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        flush_if,
    output logic        busy,
    output logic [15:0] stat_total,
    output logic [15:0] stat_taken
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EX,
        S_MEM,
        S_FLUSH
    } state_t;

    state_t      r_state;
    logic        r_is_bne;
    logic        r_taken;
    logic        r_branch_mem;
    logic        r_pc_src;
    logic        r_flush_if;
    logic        r_busy;
    logic [31:0] r_pc_branch;

    logic w_accept;
    logic w_taken;

    assign w_accept = ((instruccion == OP_BEQ) || (instruccion == OP_BNE)) && !bubble;
    assign w_taken  = r_is_bne ? ~zero : zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_bne     <= 1'b0;
            r_taken      <= 1'b0;
            r_branch_mem <= 1'b0;
            r_pc_src     <= 1'b0;
            r_flush_if   <= 1'b0;
            r_busy       <= 1'b0;
            r_pc_branch  <= 32'h0;
        end else begin
            r_branch_mem <= 1'b0;
            r_pc_src     <= 1'b0;
            r_flush_if   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_EX;
                        r_is_bne <= (instruccion == OP_BNE);
                        r_busy   <= 1'b1;
                    end
                end
                // MEM-cycle outputs are loaded here so they are registered
                S_EX: begin
                    r_taken      <= w_taken;
                    r_pc_branch  <= pc_target;
                    r_branch_mem <= 1'b1;
                    r_pc_src     <= w_taken;
                    r_flush_if   <= w_taken;
                    r_state      <= S_MEM;
                    r_busy       <= 1'b1;
                end
                S_MEM: begin
                    if (r_taken) begin
                        r_state <= S_FLUSH;
                        r_busy  <= 1'b1;
                    end else if (w_accept) begin
                        r_state  <= S_EX;
                        r_is_bne <= (instruccion == OP_BNE);
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign branch_mem = r_branch_mem;
    assign pc_src     = r_pc_src;
    assign flush_if   = r_flush_if;
    assign busy       = r_busy;
    assign pc_branch  = r_pc_branch;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_stat_total;
    logic [15:0] r_stat_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_total <= 16'h0;
            r_stat_taken <= 16'h0;
        end else if (r_state == S_MEM) begin
            if (r_stat_total != 16'hFFFF) begin
                r_stat_total <= r_stat_total + 16'h1;
            end
            if (r_taken && (r_stat_taken != 16'hFFFF)) begin
                r_stat_taken <= r_stat_taken + 16'h1;
            end
        end
    end

    assign stat_total = r_stat_total;
    assign stat_taken = r_stat_taken;
`else
    assign stat_total = 16'h0000;
    assign stat_taken = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolution.sv
// Directed bench for branch_resolution with a queue scoreboard of expected MEM pulses.
module tb_branch_resolution;

    logic        clk;
    logic        rst;
    logic [5:0]  instruccion;
    logic        bubble;
    logic        zero;
    logic [31:0] pc_target;
    logic        branch_mem;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic        flush_if;
    logic        busy;
    logic [15:0] stat_total;
    logic [15:0] stat_taken;

    typedef struct {
        logic        src;
        logic [31:0] tgt;
        logic        flush;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;

`ifdef BRANCH_STATS_EN
    localparam logic [15:0] EXP_TOT = 16'd3;
    localparam logic [15:0] EXP_TKN = 16'd2;
`else
    localparam logic [15:0] EXP_TOT = 16'd0;
    localparam logic [15:0] EXP_TKN = 16'd0;
`endif

    branch_resolution dut (
        .clk         (clk),
        .rst         (rst),
        .instruccion (instruccion),
        .bubble      (bubble),
        .zero        (zero),
        .pc_target   (pc_target),
        .branch_mem  (branch_mem),
        .pc_src      (pc_src),
        .pc_branch   (pc_branch),
        .flush_if    (flush_if),
        .busy        (busy),
        .stat_total  (stat_total),
        .stat_taken  (stat_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (branch_mem !== 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                assert (0) else begin
                    failures++;
                    $error("FAIL unexpected_branch_mem observed=%b expected=0", branch_mem);
                end
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_pc_src", {31'h0, pc_src}, {31'h0, e.src});
                check("sb_pc_branch", pc_branch, e.tgt);
                check("sb_flush_if", {31'h0, flush_if}, {31'h0, e.flush});
            end
        end
    end

    initial begin
        rst = 1'b1;
        instruccion = 6'h0;
        bubble = 1'b0;
        zero = 1'b0;
        pc_target = 32'h0;
        tick();
        rst = 1'b0;
        check("rst_branch_mem", {31'h0, branch_mem}, 32'h0);
        check("rst_pc_src", {31'h0, pc_src}, 32'h0);
        check("rst_flush_if", {31'h0, flush_if}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_pc_branch", pc_branch, 32'h0);
        check("rst_stat_total", {16'h0, stat_total}, 32'h0);
        check("rst_stat_taken", {16'h0, stat_taken}, 32'h0);

        // BNE taken
        instruccion = BNE;
        q.push_back('{src: 1'b1, tgt: 32'h40, flush: 1'b1});
        tick();
        instruccion = 6'h0;
        zero = 1'b0;
        pc_target = 32'h40;
        check("bne_ex_busy", {31'h0, busy}, 32'h1);
        check("bne_ex_bm", {31'h0, branch_mem}, 32'h0);
        tick();
        pc_target = 32'h0;
        instruccion = BEQ;
        check("bne_mem_bm", {31'h0, branch_mem}, 32'h1);
        check("bne_mem_src", {31'h0, pc_src}, 32'h1);
        check("bne_mem_tgt", pc_branch, 32'h40);
        check("bne_mem_flush", {31'h0, flush_if}, 32'h1);
        tick();
        check("bne_flush_busy", {31'h0, busy}, 32'h1);
        check("bne_flush_bm", {31'h0, branch_mem}, 32'h0);
        check("bne_flush_fl", {31'h0, flush_if}, 32'h0);
        check("bne_hold_tgt", pc_branch, 32'h40);
        tick();
        instruccion = 6'h0;
        check("bne_idle_busy", {31'h0, busy}, 32'h0);
        tick();
        check("ignored_busy", {31'h0, busy}, 32'h0);

        // BEQ not taken, then BNE back-to-back
        instruccion = BEQ;
        q.push_back('{src: 1'b0, tgt: 32'h80, flush: 1'b0});
        tick();
        instruccion = 6'h0;
        zero = 1'b0;
        pc_target = 32'h80;
        tick();
        check("beq_mem_bm", {31'h0, branch_mem}, 32'h1);
        check("beq_mem_src", {31'h0, pc_src}, 32'h0);
        check("beq_mem_flush", {31'h0, flush_if}, 32'h0);
        instruccion = BNE;
        q.push_back('{src: 1'b1, tgt: 32'hC0, flush: 1'b1});
        tick();
        instruccion = BEQ;
        zero = 1'b0;
        pc_target = 32'hC0;
        check("b2b_ex_busy", {31'h0, busy}, 32'h1);
        check("b2b_ex_bm", {31'h0, branch_mem}, 32'h0);
        tick();
        instruccion = 6'h0;
        check("b2b_mem_bm", {31'h0, branch_mem}, 32'h1);
        check("b2b_mem_tgt", pc_branch, 32'hC0);
        tick();
        check("b2b_flush_busy", {31'h0, busy}, 32'h1);
        tick();
        check("b2b_idle_busy", {31'h0, busy}, 32'h0);

        // non-branch and bubble
        instruccion = 6'b100010;
        tick();
        check("nonbr_busy", {31'h0, busy}, 32'h0);
        instruccion = BEQ;
        bubble = 1'b1;
        tick();
        check("bubble_busy", {31'h0, busy}, 32'h0);
        tick();
        instruccion = 6'h0;
        bubble = 1'b0;
        check("bubble_busy2", {31'h0, busy}, 32'h0);
        check("stat_total", {16'h0, stat_total}, {16'h0, EXP_TOT});
        check("stat_taken", {16'h0, stat_taken}, {16'h0, EXP_TKN});

        // reset in EX
        instruccion = BEQ;
        tick();
        instruccion = 6'h0;
        zero = 1'b1;
        check("midrst_ex_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_bm", {31'h0, branch_mem}, 32'h0);
        check("midrst_tgt", pc_branch, 32'h0);
        check("midrst_stat", {16'h0, stat_total}, 32'h0);
        tick();
        check("midrst_bm2", {31'h0, branch_mem}, 32'h0);
        check("midrst_busy2", {31'h0, busy}, 32'h0);
        tick();
        tick();
        check("sb_empty", q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
